// File: rtl/watch_alarm_ctrl_if.sv
// Alarm-time write channel: the setter presents a time with a strobe,
// and the alarm controller answers with a one-cycle reject pulse.
interface watch_alarm_ctrl_if #(
   parameter int P_MIN_BIT  = 6,
   parameter int P_HOUR_BIT = 5
);
   logic                  i_set_valid;
   logic [P_HOUR_BIT-1:0] i_set_hour;
   logic [P_MIN_BIT-1:0]  i_set_min;
   logic                  o_set_err;

   modport master (output i_set_valid, i_set_hour, i_set_min, input o_set_err);
   modport slave  (input i_set_valid, i_set_hour, i_set_min, output o_set_err);
endinterface

// File: rtl/watch_alarm_ctrl.sv
// Alarm controller: compares the running watch time against a stored alarm
// time, rings for a bounded number of seconds, and supports a limited number
// of snoozes per alarm event.
module watch_alarm_ctrl #(
   parameter int P_SEC_BIT    = 6,
   parameter int P_MIN_BIT    = 6,
   parameter int P_HOUR_BIT   = 5,
   parameter int P_RING_SEC   = 60,
   parameter int P_SNOOZE_SEC = 300,
   parameter int P_MAX_SNOOZE = 3
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  i_sec_tick,
   input  logic [P_SEC_BIT-1:0]  i_sec,
   input  logic [P_MIN_BIT-1:0]  i_min,
   input  logic [P_HOUR_BIT-1:0] i_hour,
   input  logic                  i_alarm_en,
   watch_alarm_ctrl_if.slave     set_if,
   input  logic                  i_snooze,
   input  logic                  i_stop,
   output logic [P_HOUR_BIT-1:0] o_alarm_hour,
   output logic [P_MIN_BIT-1:0]  o_alarm_min,
   output logic                  o_ring,
   output logic                  o_snoozing,
   output logic                  o_missed,
   output logic [1:0]            o_snooze_left
);

   localparam int RING_W = $clog2(P_RING_SEC + 1);
   localparam int SNZ_W  = $clog2(P_SNOOZE_SEC + 1);

   typedef enum logic [1:0] {ST_IDLE, ST_RING, ST_SNOOZE} state_e;

   state_e                state_q, state_d;
   logic [RING_W-1:0]     ring_cnt_q, ring_cnt_d;
   logic [SNZ_W-1:0]      snz_cnt_q, snz_cnt_d;
   logic [1:0]            left_q, left_d;
   logic [P_HOUR_BIT-1:0] hour_q, hour_d;
   logic [P_MIN_BIT-1:0]  min_q, min_d;
   logic                  err_q, err_d;
   logic                  missed_q, missed_d;
   logic                  ring_q, snoozing_q;
   logic                  set_ok;

   // Next state, counters and stored time; one priority chain decides the state.
   always_comb begin
      state_d    = state_q;
      ring_cnt_d = ring_cnt_q;
      snz_cnt_d  = snz_cnt_q;
      left_d     = left_q;
      hour_d     = hour_q;
      min_d      = min_q;
      err_d      = 1'b0;
      missed_d   = 1'b0;
      set_ok     = (32'(set_if.i_set_hour) < 32'd24) && (32'(set_if.i_set_min) < 32'd60);

      // Storing the time is independent of the state priority chain below.
      if (set_if.i_set_valid) begin
         if (set_ok) begin
            hour_d = set_if.i_set_hour;
            min_d  = set_if.i_set_min;
         end else begin
            err_d = 1'b1;
         end
      end

      if (!i_alarm_en) begin
         state_d    = ST_IDLE;
         ring_cnt_d = '0;
         snz_cnt_d  = '0;
      end else if (set_if.i_set_valid) begin
         // A rejected write freezes everything else for that cycle.
         if (set_ok) begin
            state_d    = ST_IDLE;
            ring_cnt_d = '0;
            snz_cnt_d  = '0;
         end
      end else if (i_stop && state_q != ST_IDLE) begin
         state_d    = ST_IDLE;
         ring_cnt_d = '0;
         snz_cnt_d  = '0;
      end else if (i_snooze && state_q == ST_RING && left_q != 2'd0) begin
         state_d    = ST_SNOOZE;
         ring_cnt_d = '0;
         snz_cnt_d  = SNZ_W'(P_SNOOZE_SEC);
         left_d     = left_q - 2'd1;
      end else if (i_sec_tick) begin
         case (state_q)
            ST_IDLE: begin
               if (i_hour == hour_q && i_min == min_q && i_sec == '0) begin
                  state_d    = ST_RING;
                  ring_cnt_d = '0;
                  left_d     = 2'(P_MAX_SNOOZE);
               end
            end
            ST_RING: begin
               if (ring_cnt_q == RING_W'(P_RING_SEC - 1)) begin
                  state_d    = ST_IDLE;
                  ring_cnt_d = '0;
                  missed_d   = 1'b1;
               end else begin
                  ring_cnt_d = ring_cnt_q + RING_W'(1);
               end
            end
            ST_SNOOZE: begin
               if (snz_cnt_q == SNZ_W'(1)) begin
                  state_d    = ST_RING;
                  ring_cnt_d = '0;
                  snz_cnt_d  = '0;
               end else begin
                  snz_cnt_d = snz_cnt_q - SNZ_W'(1);
               end
            end
            default: state_d = ST_IDLE;
         endcase
      end
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= ST_IDLE;
         ring_cnt_q <= '0;
         snz_cnt_q  <= '0;
         left_q     <= '0;
         hour_q     <= '0;
         min_q      <= '0;
         err_q      <= 1'b0;
         missed_q   <= 1'b0;
         ring_q     <= 1'b0;
         snoozing_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         ring_cnt_q <= ring_cnt_d;
         snz_cnt_q  <= snz_cnt_d;
         left_q     <= left_d;
         hour_q     <= hour_d;
         min_q      <= min_d;
         err_q      <= err_d;
         missed_q   <= missed_d;
         ring_q     <= (state_d == ST_RING);
         snoozing_q <= (state_d == ST_SNOOZE);
      end
   end

   assign o_alarm_hour     = hour_q;
   assign o_alarm_min      = min_q;
   assign o_ring           = ring_q;
   assign o_snoozing       = snoozing_q;
   assign o_missed         = missed_q;
   assign o_snooze_left    = left_q;
   assign set_if.o_set_err = err_q;

endmodule

// File: tb/tb_watch_alarm_ctrl.sv
// Bench for watch_alarm_ctrl: directed scenarios plus a randomized run
// checked against a behavioural alarm model.
module tb_watch_alarm_ctrl;

   localparam int RING_SEC   = 60;
   localparam int SNOOZE_SEC = 300;
   localparam int MAX_SNOOZE = 3;

   logic       clk, rst, tick, en, snooze, stop;
   logic [5:0] sec, min;
   logic [4:0] hour;
   logic [4:0] o_alarm_hour;
   logic [5:0] o_alarm_min;
   logic       o_ring, o_snoozing, o_missed;
   logic [1:0] o_snooze_left;

   int n_cmp = 0;
   int n_err = 0;

   watch_alarm_ctrl_if #(.P_MIN_BIT(6), .P_HOUR_BIT(5)) set_bus ();

   watch_alarm_ctrl #(
      .P_SEC_BIT(6), .P_MIN_BIT(6), .P_HOUR_BIT(5),
      .P_RING_SEC(RING_SEC), .P_SNOOZE_SEC(SNOOZE_SEC), .P_MAX_SNOOZE(MAX_SNOOZE)
   ) dut (
      .clk(clk), .reset(rst), .i_sec_tick(tick), .i_sec(sec), .i_min(min), .i_hour(hour),
      .i_alarm_en(en), .set_if(set_bus), .i_snooze(snooze), .i_stop(stop),
      .o_alarm_hour(o_alarm_hour), .o_alarm_min(o_alarm_min), .o_ring(o_ring),
      .o_snoozing(o_snoozing), .o_missed(o_missed), .o_snooze_left(o_snooze_left)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Behavioural model: whether the alarm is sounding, whether it is snoozed,
   // seconds rung so far, seconds until wake-up, snoozes still allowed.
   bit         m_ringing = 0, m_snoozed = 0, m_err = 0, m_missed = 0;
   int         m_rung = 0, m_wake = 0, m_left = 0;
   logic [4:0] m_ah = '0;
   logic [5:0] m_am = '0;

   task automatic model_step();
      bit ok, active;
      ok = set_bus.i_set_valid && (set_bus.i_set_hour < 24) && (set_bus.i_set_min < 60);
      if (rst) begin
         m_ringing = 0; m_snoozed = 0; m_err = 0; m_missed = 0;
         m_rung = 0; m_wake = 0; m_left = 0; m_ah = '0; m_am = '0;
         return;
      end
      m_err = set_bus.i_set_valid && !ok;
      m_missed = 0;
      if (ok) begin m_ah = set_bus.i_set_hour; m_am = set_bus.i_set_min; end
      active = m_ringing || m_snoozed;
      if (!en) begin
         m_ringing = 0; m_snoozed = 0;
      end else if (set_bus.i_set_valid) begin
         if (ok) begin m_ringing = 0; m_snoozed = 0; end
      end else if (stop && active) begin
         m_ringing = 0; m_snoozed = 0;
      end else if (snooze && m_ringing && m_left > 0) begin
         m_ringing = 0; m_snoozed = 1; m_wake = SNOOZE_SEC; m_left--;
      end else if (tick) begin
         if (m_ringing) begin
            m_rung++;
            if (m_rung == RING_SEC) begin m_ringing = 0; m_missed = 1; end
         end else if (m_snoozed) begin
            m_wake--;
            if (m_wake == 0) begin m_snoozed = 0; m_ringing = 1; m_rung = 0; end
         end else if (hour == m_ah && min == m_am && sec == 0) begin
            m_ringing = 1; m_rung = 0; m_left = MAX_SNOOZE;
         end
      end
   endtask

   task automatic cycle();
      model_step();
      @(posedge clk);
      #1;
      tick = 0; snooze = 0; stop = 0; set_bus.i_set_valid = 0;
   endtask

   task automatic do_set(input logic [4:0] h, input logic [5:0] m);
      set_bus.i_set_valid = 1; set_bus.i_set_hour = h; set_bus.i_set_min = m;
      cycle();
   endtask

   task automatic do_tick(input logic [4:0] h, input logic [5:0] m, input logic [5:0] s);
      tick = 1; hour = h; min = m; sec = s;
      cycle();
   endtask

   task automatic test_reset();
      rst = 1; cycle(); cycle();
      n_cmp++;
      if ({o_ring, o_snoozing, o_missed, set_bus.o_set_err, o_snooze_left, o_alarm_hour, o_alarm_min} !== 17'd0) begin
         n_err++;
         $display("FAIL reset_state: got %b expected all zero",
            {o_ring, o_snoozing, o_missed, set_bus.o_set_err, o_snooze_left, o_alarm_hour, o_alarm_min});
      end
      rst = 0;
   endtask

   task automatic test_trigger();
      en = 1;
      do_set(7, 30);
      n_cmp++;
      if ({o_alarm_hour, o_alarm_min, set_bus.o_set_err} !== {5'd7, 6'd30, 1'b0}) begin
         n_err++; $display("FAIL set_0730: got %0d:%0d err %b expected 7:30 err 0", o_alarm_hour, o_alarm_min, set_bus.o_set_err);
      end
      do_tick(7, 29, 59);
      n_cmp++;
      if (o_ring !== 1'b0) begin n_err++; $display("FAIL no_ring_0729: got %b expected 0", o_ring); end
      do_tick(7, 30, 0);
      n_cmp++;
      if ({o_ring, o_snooze_left} !== {1'b1, 2'd3}) begin
         n_err++; $display("FAIL trigger_0730: ring %b left %0d expected ring 1 left 3", o_ring, o_snooze_left);
      end
      stop = 1; cycle();
      n_cmp++;
      if (o_ring !== 1'b0) begin n_err++; $display("FAIL stop_ring: got %b expected 0", o_ring); end
      en = 0; cycle();
      do_tick(7, 30, 0);
      n_cmp++;
      if (o_ring !== 1'b0) begin n_err++; $display("FAIL disabled_no_ring: got %b expected 0", o_ring); end
      en = 1;
      do_tick(7, 30, 0);
      stop = 1; cycle();
      do_tick(7, 30, 1);
      n_cmp++;
      if (o_ring !== 1'b0) begin n_err++; $display("FAIL no_retrigger: got %b expected 0", o_ring); end
   endtask

   task automatic test_timeout();
      bit bad = 0;
      do_tick(7, 30, 0);
      for (int i = 1; i < RING_SEC; i++) begin
         do_tick(12, 0, 5);
         if (o_ring !== 1'b1 || o_missed !== 1'b0) bad = 1;
      end
      n_cmp++;
      if (bad) begin n_err++; $display("FAIL ring_hold: ring/missed wrong before tick %0d expected ring 1 missed 0", RING_SEC); end
      do_tick(12, 0, 5);
      n_cmp++;
      if ({o_ring, o_missed} !== 2'b01) begin
         n_err++; $display("FAIL timeout: ring %b missed %b expected ring 0 missed 1", o_ring, o_missed);
      end
      cycle();
      n_cmp++;
      if (o_missed !== 1'b0) begin n_err++; $display("FAIL missed_pulse: got %b expected 0", o_missed); end
   endtask

   task automatic test_snooze();
      logic [1:0] exp_left;
      do_tick(7, 30, 0);
      for (int k = 0; k < MAX_SNOOZE; k++) begin
         exp_left = 2'(MAX_SNOOZE - 1 - k);
         snooze = 1; cycle();
         n_cmp++;
         if ({o_ring, o_snoozing, o_snooze_left} !== {1'b0, 1'b1, exp_left}) begin
            n_err++; $display("FAIL snooze_%0d: ring %b snz %b left %0d expected 0 1 %0d", k, o_ring, o_snoozing, o_snooze_left, exp_left);
         end
         repeat (SNOOZE_SEC - 1) do_tick(12, 0, 5);
         n_cmp++;
         if ({o_ring, o_snoozing} !== 2'b01) begin
            n_err++; $display("FAIL snooze_hold_%0d: ring %b snz %b expected 0 1", k, o_ring, o_snoozing);
         end
         do_tick(12, 0, 5);
         n_cmp++;
         if ({o_ring, o_snoozing} !== 2'b10) begin
            n_err++; $display("FAIL snooze_wake_%0d: ring %b snz %b expected 1 0", k, o_ring, o_snoozing);
         end
      end
      snooze = 1; cycle();
      n_cmp++;
      if ({o_ring, o_snoozing, o_snooze_left} !== {1'b1, 1'b0, 2'd0}) begin
         n_err++; $display("FAIL snooze_exhausted: ring %b snz %b left %0d expected 1 0 0", o_ring, o_snoozing, o_snooze_left);
      end
      stop = 1; cycle();
   endtask

   task automatic test_set_err();
      do_set(24, 10);
      n_cmp++;
      if ({set_bus.o_set_err, o_alarm_hour, o_alarm_min} !== {1'b1, 5'd7, 6'd30}) begin
         n_err++; $display("FAIL set_hour24: err %b time %0d:%0d expected err 1 7:30", set_bus.o_set_err, o_alarm_hour, o_alarm_min);
      end
      cycle();
      n_cmp++;
      if (set_bus.o_set_err !== 1'b0) begin n_err++; $display("FAIL err_pulse: got %b expected 0", set_bus.o_set_err); end
      do_set(5, 60);
      n_cmp++;
      if ({set_bus.o_set_err, o_alarm_hour, o_alarm_min} !== {1'b1, 5'd7, 6'd30}) begin
         n_err++; $display("FAIL set_min60: err %b time %0d:%0d expected err 1 7:30", set_bus.o_set_err, o_alarm_hour, o_alarm_min);
      end
      do_set(23, 59);
      n_cmp++;
      if ({set_bus.o_set_err, o_alarm_hour, o_alarm_min} !== {1'b0, 5'd23, 6'd59}) begin
         n_err++; $display("FAIL set_2359: err %b time %0d:%0d expected err 0 23:59", set_bus.o_set_err, o_alarm_hour, o_alarm_min);
      end
   endtask

   task automatic test_stop_snooze();
      do_tick(23, 59, 0);
      stop = 1; snooze = 1; cycle();
      n_cmp++;
      if ({o_ring, o_snoozing, o_snooze_left} !== {1'b0, 1'b0, 2'd3}) begin
         n_err++; $display("FAIL stop_and_snooze: ring %b snz %b left %0d expected 0 0 3", o_ring, o_snoozing, o_snooze_left);
      end
   endtask

   task automatic test_back_to_back();
      do_tick(23, 59, 0);
      do_set(1, 2);
      n_cmp++;
      if ({o_ring, o_alarm_hour, o_alarm_min} !== {1'b0, 5'd1, 6'd2}) begin
         n_err++; $display("FAIL write_in_ring: ring %b time %0d:%0d expected 0 1:2", o_ring, o_alarm_hour, o_alarm_min);
      end
      tick = 1; hour = 1; min = 2; sec = 0;
      do_set(1, 2);
      n_cmp++;
      if (o_ring !== 1'b0) begin n_err++; $display("FAIL write_blocks_trigger: got %b expected 0", o_ring); end
      do_tick(1, 2, 0);
      n_cmp++;
      if (o_ring !== 1'b1) begin n_err++; $display("FAIL trigger_after_write: got %b expected 1", o_ring); end
      stop = 1; cycle();
   endtask

   task automatic test_reset_mid_snooze();
      do_tick(1, 2, 0);
      snooze = 1; cycle();
      n_cmp++;
      if (o_snoozing !== 1'b1) begin n_err++; $display("FAIL pre_reset_snooze: got %b expected 1", o_snoozing); end
      rst = 1; cycle();
      n_cmp++;
      if ({o_ring, o_snoozing, o_missed, set_bus.o_set_err, o_snooze_left, o_alarm_hour, o_alarm_min} !== 17'd0) begin
         n_err++;
         $display("FAIL reset_in_snooze: got %b expected all zero",
            {o_ring, o_snoozing, o_missed, set_bus.o_set_err, o_snooze_left, o_alarm_hour, o_alarm_min});
      end
      rst = 0;
      do_tick(0, 0, 0);
      n_cmp++;
      if (o_ring !== 1'b1) begin n_err++; $display("FAIL ring_after_reset: got %b expected 1", o_ring); end
      stop = 1; cycle();
   endtask

   task automatic test_random();
      logic [17:0] exp_v, got_v;
      for (int c = 0; c < 6000; c++) begin
         en     = ($urandom_range(0, 199) != 0);
         tick   = ($urandom_range(0, 1) == 1);
         snooze = ($urandom_range(0, 19) == 0);
         stop   = ($urandom_range(0, 79) == 0);
         hour   = ($urandom_range(0, 2) == 0) ? m_ah : 5'($urandom_range(0, 23));
         min    = ($urandom_range(0, 2) == 0) ? m_am : 6'($urandom_range(0, 59));
         sec    = ($urandom_range(0, 2) == 0) ? 6'd0 : 6'($urandom_range(0, 59));
         if (!tick && en && $urandom_range(0, 99) == 0) begin
            set_bus.i_set_valid = 1;
            set_bus.i_set_hour  = 5'($urandom_range(0, 26));
            set_bus.i_set_min   = 6'($urandom_range(0, 63));
         end
         cycle();
         exp_v = {m_ringing, m_snoozed, m_missed, m_err, 2'(m_left), m_ah, m_am};
         got_v = {o_ring, o_snoozing, o_missed, set_bus.o_set_err, o_snooze_left, o_alarm_hour, o_alarm_min};
         n_cmp++;
         if (got_v !== exp_v) begin
            n_err++; $display("FAIL random_cyc%0d: got %b expected %b", c, got_v, exp_v);
         end
      end
      en = 1;
   endtask

   initial begin
      rst = 1; tick = 0; en = 0; snooze = 0; stop = 0;
      sec = '0; min = '0; hour = '0;
      set_bus.i_set_valid = 0; set_bus.i_set_hour = '0; set_bus.i_set_min = '0;
      test_reset();
      test_trigger();
      test_timeout();
      test_snooze();
      test_set_err();
      test_stop_snooze();
      test_back_to_back();
      test_reset_mid_snooze();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/watch_alarm_ctrl.md
WATCH_ALARM_CTRL -- requirements
Module: watch_alarm_ctrl

Interface
REQ-001 Parameter P_SEC_BIT, default 6: width of seconds input.
REQ-002 Parameter P_MIN_BIT, default 6: width of minutes input and alarm minute.
REQ-003 Parameter P_HOUR_BIT, default 5: width of hours input and alarm hour.
REQ-004 Parameter P_RING_SEC, default 60: ticks the alarm rings before auto-stop.
REQ-005 Parameter P_SNOOZE_SEC, default 300: ticks per snooze interval.
REQ-006 Parameter P_MAX_SNOOZE, default 3: snoozes allowed per alarm event.
REQ-007 clk  in  1  clock; all logic on rising edge.
REQ-008 reset  in  1  synchronous, active-high reset.
REQ-009 i_sec_tick  in  1  one-cycle pulse, once per second, from the watch tick stage.
REQ-010 i_sec / i_min / i_hour  in  P_SEC_BIT / P_MIN_BIT / P_HOUR_BIT  current time from the watch tick stage.
REQ-011 i_alarm_en  in  1  level; alarm armed when high.
REQ-012 i_set_valid  in  1  one-cycle alarm-time write strobe.
REQ-013 i_set_hour / i_set_min  in  P_HOUR_BIT / P_MIN_BIT  alarm time to write.
REQ-014 i_snooze / i_stop  in  1  one-cycle user button pulses.
REQ-015 o_alarm_hour / o_alarm_min  out  P_HOUR_BIT / P_MIN_BIT  stored alarm time.
REQ-016 o_ring  out  1  high while state RING.
REQ-017 o_snoozing  out  1  high while state SNOOZE.
REQ-018 o_set_err  out  1  one-cycle pulse on rejected write.
REQ-019 o_missed  out  1  one-cycle pulse on ring timeout.
REQ-020 o_snooze_left  out  2  snoozes remaining in the current event.

Function
REQ-021 States: IDLE, RING, SNOOZE; all outputs registered.
REQ-022 Trigger: cycle with i_sec_tick=1, i_alarm_en=1, state IDLE, i_hour==o_alarm_hour, i_min==o_alarm_min, i_sec==0.
REQ-023 Trigger -> RING next cycle; o_ring high the cycle after trigger; ring counter cleared; o_snooze_left loaded with P_MAX_SNOOZE.
REQ-024 RING: ring counter increments per i_sec_tick; on the tick making it equal P_RING_SEC -> IDLE with o_missed pulse.
REQ-025 RING + i_snooze with o_snooze_left>0 -> SNOOZE; snooze counter loaded P_SNOOZE_SEC; o_snooze_left decremented.
REQ-026 RING + i_snooze with o_snooze_left==0: ignored, stays RING, ring counter continues.
REQ-027 SNOOZE: snooze counter decrements per i_sec_tick; on the tick where it equals 1 -> RING, ring counter cleared.
REQ-028 i_stop in RING or SNOOZE -> IDLE next cycle, no o_missed.
REQ-029 i_alarm_en low -> IDLE next cycle from any state; counters cleared.
REQ-030 Priority within one cycle: reset > i_alarm_en low > i_set_valid > i_stop > i_snooze > tick-driven transitions.
REQ-031 Write accepted only if i_set_hour<24 and i_set_min<60: stored next cycle; if state RING or SNOOZE, state -> IDLE.
REQ-032 Invalid write: stored time unchanged, state unchanged, o_set_err pulses next cycle.
REQ-033 Trigger never fires in the same cycle as an accepted write; the new time applies from the next tick.
REQ-034 Re-trigger: returning to IDLE within the matching second does not re-trigger (i_sec must be 0 on a tick).
REQ-035 Ring counter width ceil(log2(P_RING_SEC+1)); snooze counter width ceil(log2(P_SNOOZE_SEC+1)); no wrap.
REQ-036 i_snooze / i_stop in IDLE: ignored.

Reset
REQ-037 On reset: state IDLE, o_alarm_hour=0, o_alarm_min=0, o_ring=0, o_snoozing=0, o_set_err=0, o_missed=0, o_snooze_left=0, counters 0.
REQ-038 Reset mid-RING or mid-SNOOZE: same values next cycle; stored alarm time lost.

Verification
REQ-039 Set 07:30, en=1, tick with time 07:30:00 -> o_ring=1 the cycle after trigger; 07:30:00 with en=0 -> no ring.
REQ-040 Ring with no input for 60 ticks -> o_missed pulse on 60th tick, o_ring=0 next cycle.
REQ-041 Ring, i_snooze -> o_snoozing=1, o_snooze_left=2; 300 ticks later -> o_ring=1; repeat 3 times; 4th i_snooze ignored.
REQ-042 i_set_valid hour=24 min=10 -> o_set_err pulse, alarm unchanged; hour=23 min=59 -> stored, no err.
REQ-043 Same cycle i_stop and i_snooze while RING -> IDLE, o_snooze_left unchanged.
REQ-044 Reset asserted during SNOOZE -> all outputs at reset values; following tick at 00:00:00 with en=1 -> rings.
